fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch control stage that drives the 16-bit program-counter register (register_16) and consumes its output.
- Reads the PC value and issues a memory read at that address using a req/ack handshake.
- Presents the fetched word to decode with a valid/ready handshake.
- Pulses the PC register's increment enable after each fetch, and its write enable for branch redirects.

Parameters:
- DATA_WIDTH, 16, instruction word width.
- ADDR_WIDTH, 16, PC/memory address width; must match the register_16 width.

Ports:
- clk  in  1  system clock; all logic updates on the rising edge.
- rst_en  in  1  synchronous, active-high reset.
- start  in  1  begin fetching from the current pc_in (level, sampled in IDLE).
- halt  in  1  stop after the instruction in flight is delivered.
- pc_in  in  ADDR_WIDTH  current PC, from the PC register's data_out.
- pc_inc_en  out  1  one-cycle pulse to the PC register's inc_en.
- pc_write_en  out  1  one-cycle pulse to the PC register's write_en.
- pc_load_val  out  ADDR_WIDTH  branch target, to the PC register's data_in.
- branch_req  in  1  redirect request from execute.
- branch_target  in  ADDR_WIDTH  redirect address.
- mem_addr  out  ADDR_WIDTH  read address.
- mem_rd_req  out  1  read request; held until ack.
- mem_rd_ack  in  1  read complete; mem_rd_data is valid in the same cycle.
- mem_rd_data  in  DATA_WIDTH  read data.
- instr  out  DATA_WIDTH  fetched instruction.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  decode accepts instr.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered.
- On a reset edge: state returns to IDLE; all outputs and the internal halt_pending, br_pending and br_target registers go to 0. This applies mid-operation: mem_rd_req drops on the next edge and any outstanding memory reply is ignored.
- States: IDLE, REQ, DELIVER, FLUSH.
- IDLE:
  - mem_rd_req = 0, instr_valid = 0.
  - Move to REQ when start = 1 and halt = 0.
  - branch_req is ignored.
- REQ:
  - mem_rd_req = 1, mem_addr = pc_in, sampled each cycle. pc_in is stable in REQ because the fetch unit issues no PC pulses in this state.
  - The request is never withdrawn before mem_rd_ack, except by reset.
  - On ack with br_pending = 0: instr <= mem_rd_data, instr_valid <= 1, pc_inc_en <= 1 for exactly one cycle, next state DELIVER.
  - On ack with br_pending = 1: data is discarded, no pc_inc_en, next state FLUSH.
- DELIVER:
  - instr and instr_valid are held stable until instr_ready = 1.
  - The PC increments at the end of the first DELIVER cycle.
  - On handshake (instr_valid and instr_ready): instr_valid <= 0; next state is IDLE if halt_pending, otherwise REQ.
- FLUSH:
  - Exactly one cycle: pc_write_en = 1, pc_load_val = br_target, instr_valid = 0.
  - Clears br_pending.
  - Next state is IDLE if halt_pending, otherwise REQ. The next REQ fetches from br_target.
- Branch handling:
  - A branch_req sampled in REQ sets br_pending and latches br_target.
  - A branch_req sampled in DELIVER latches br_target and goes directly to FLUSH; instr_valid drops.
  - If branch_req and an instr handshake occur in the same cycle, the instruction counts as consumed and the branch is still taken.
  - A later branch_req overwrites br_target.
  - In FLUSH, a new branch_req replaces br_target and FLUSH repeats for one more cycle.
- halt:
  - halt = 1 in any non-IDLE state sets halt_pending, which clears on entry to IDLE.
  - If halt and start are both high in IDLE, halt wins.
- pc_inc_en and pc_write_en are never high in the same cycle.
- busy = (state != IDLE).
- Addresses wrap naturally; PC overflow is the PC register's concern.

Test Plan:
- Reset, then start with pc_in = 0x0010; memory acks after 2 cycles with 0xA55A -> mem_addr = 0x0010; instr = 0xA55A with instr_valid = 1; one pc_inc_en pulse; next fetch issued to 0x0011 with instr_ready held at 1.
- Back-pressure: instr_ready = 0 for 5 cycles -> instr stays 0xA55A, instr_valid stays 1, no new mem_rd_req, only one pc_inc_en pulse.
- branch_req with target 0x0200 while in REQ and ack pending -> acked data is not presented, no pc_inc_en, one pc_write_en pulse with pc_load_val = 0x0200, next mem_addr = 0x0200.
- branch_req with target 0x0300 in DELIVER, together with instr_ready = 1 -> instruction consumed, instr_valid = 0 the next cycle, pc_write_en pulse to 0x0300, next fetch from 0x0300.
- halt asserted during REQ -> the in-flight instruction is delivered, then state is IDLE, busy = 0, no further mem_rd_req; start = 1 with halt = 1 in IDLE stays IDLE.
- rst_en asserted while mem_rd_req = 1 -> all outputs are 0 the following cycle; a late mem_rd_ack is ignored; instr_valid stays 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: reads the PC, fetches one word over req/ack,
// hands it to decode over valid/ready and steers the PC register (increment / branch load).
module fetch_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_en,
    input  logic                  start,
    input  logic                  halt,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  pc_inc_en,
    output logic                  pc_write_en,
    output logic [ADDR_WIDTH-1:0] pc_load_val,
    input  logic                  branch_req,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_req,
    input  logic                  mem_rd_ack,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  busy
);

    // state   | meaning
    // IDLE    | no fetch activity, waiting for start
    // REQ     | memory read outstanding at the current PC
    // DELIVER | fetched word offered to decode
    // FLUSH   | one-cycle PC load with the branch target
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DELIVER = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    halt_pending_q;
    logic                    br_pending_q;
    logic [ADDR_WIDTH-1:0]   br_target_q;
    logic                    pc_inc_en_q;
    logic                    pc_write_en_q;
    logic [ADDR_WIDTH-1:0]   pc_load_val_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    mem_rd_req_q;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic                    instr_valid_q;
    logic                    busy_q;

    logic                    halt_now;
    logic                    ack_take;
    logic                    br_now;
    logic [ADDR_WIDTH-1:0]   br_target_d;

    // An ack only counts against a request we are actually driving; stale replies are dropped.
    assign halt_now    = halt_pending_q | halt;
    assign ack_take    = mem_rd_req_q & mem_rd_ack;
    assign br_now      = br_pending_q | branch_req;
    assign br_target_d = branch_req ? branch_target : br_target_q;

    always_ff @(posedge clk) begin
        if (rst_en) begin
            state_q        <= IDLE;
            halt_pending_q <= 1'b0;
            br_pending_q   <= 1'b0;
            br_target_q    <= '0;
            pc_inc_en_q    <= 1'b0;
            pc_write_en_q  <= 1'b0;
            pc_load_val_q  <= '0;
            mem_addr_q     <= '0;
            mem_rd_req_q   <= 1'b0;
            instr_q        <= '0;
            instr_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            pc_inc_en_q   <= 1'b0;
            pc_write_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    halt_pending_q <= 1'b0;
                    mem_rd_req_q   <= 1'b0;
                    instr_valid_q  <= 1'b0;
                    if (start && !halt) begin
                        state_q <= REQ;
                        busy_q  <= 1'b1;
                    end
                end
                REQ: begin
                    halt_pending_q <= halt_now;
                    if (branch_req) begin
                        br_pending_q <= 1'b1;
                        br_target_q  <= branch_target;
                    end
                    // Request rises one cycle after entry so pc_in already reflects the last PC pulse.
                    if (ack_take) begin
                        mem_rd_req_q <= 1'b0;
                        if (br_now) begin
                            pc_write_en_q <= 1'b1;
                            pc_load_val_q <= br_target_d;
                            state_q       <= FLUSH;
                        end else begin
                            instr_q       <= mem_rd_data;
                            instr_valid_q <= 1'b1;
                            pc_inc_en_q   <= 1'b1;
                            state_q       <= DELIVER;
                        end
                    end else begin
                        mem_rd_req_q <= 1'b1;
                        mem_addr_q   <= pc_in;
                    end
                end
                DELIVER: begin
                    halt_pending_q <= halt_now;
                    if (branch_req) begin
                        br_target_q   <= branch_target;
                        instr_valid_q <= 1'b0;
                        pc_write_en_q <= 1'b1;
                        pc_load_val_q <= branch_target;
                        state_q       <= FLUSH;
                    end else if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        if (halt_now) begin
                            halt_pending_q <= 1'b0;
                            busy_q         <= 1'b0;
                            state_q        <= IDLE;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                FLUSH: begin
                    if (branch_req) begin
                        halt_pending_q <= halt_now;
                        br_target_q    <= branch_target;
                        pc_write_en_q  <= 1'b1;
                        pc_load_val_q  <= branch_target;
                    end else begin
                        br_pending_q <= 1'b0;
                        if (halt_now) begin
                            halt_pending_q <= 1'b0;
                            busy_q         <= 1'b0;
                            state_q        <= IDLE;
                        end else begin
                            halt_pending_q <= 1'b0;
                            state_q        <= REQ;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pc_inc_en   = pc_inc_en_q;
    assign pc_write_en = pc_write_en_q;
    assign pc_load_val = pc_load_val_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd_req  = mem_rd_req_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC register and memory models around the DUT,
// expected fetch addresses, instructions and branch loads checked from queues.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_en = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] pc_in;
    logic        pc_inc_en;
    logic        pc_write_en;
    logic [15:0] pc_load_val;
    logic        branch_req = 1'b0;
    logic [15:0] branch_target = 16'h0;
    logic [15:0] mem_addr;
    logic        mem_rd_req;
    logic        mem_rd_ack;
    logic [15:0] mem_rd_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int inc_cnt  = 0;
    int wr_cnt   = 0;
    int lat      = 2;
    bit late_ack = 1'b0;
    bit mon_en   = 1'b0;

    logic [15:0] pc_reg = 16'h0;
    logic        pc_preset_en = 1'b0;
    logic [15:0] pc_preset_val = 16'h0;

    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_instr_q[$];
    logic [15:0] exp_load_q[$];

    fetch_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clk          (clk),
        .rst_en       (rst_en),
        .start        (start),
        .halt         (halt),
        .pc_in        (pc_in),
        .pc_inc_en    (pc_inc_en),
        .pc_write_en  (pc_write_en),
        .pc_load_val  (pc_load_val),
        .branch_req   (branch_req),
        .branch_target(branch_target),
        .mem_addr     (mem_addr),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_ack   (mem_rd_ack),
        .mem_rd_data  (mem_rd_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA54A;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // PC register model (register_16): load wins over increment.
    always @(posedge clk) begin
        if (pc_preset_en)     pc_reg <= pc_preset_val;
        else if (pc_write_en) pc_reg <= pc_load_val;
        else if (pc_inc_en)   pc_reg <= pc_reg + 16'h1;
    end
    assign pc_in = pc_reg;

    // Memory model: acks a held request after lat cycles, checks the address on ack.
    initial begin
        int cnt;
        cnt = 0;
        mem_rd_ack  = 1'b0;
        mem_rd_data = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_rd_ack = 1'b0;
            if (late_ack) begin
                mem_rd_ack  = 1'b1;
                mem_rd_data = 16'hDEAD;
                late_ack    = 1'b0;
                cnt         = 0;
            end else if (mem_rd_req === 1'b1) begin
                if (cnt == lat) begin
                    mem_rd_ack  = 1'b1;
                    mem_rd_data = mem_word(mem_addr);
                    cnt         = 0;
                    if (exp_addr_q.size() == 0) check_eq("addr_extra", 32'(exp_addr_q.size()), 32'd1);
                    else                        check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Output monitor on the falling edge.
    always @(negedge clk) begin
        if (mon_en && !rst_en) begin
            if (pc_inc_en === 1'b1) inc_cnt++;
            if (pc_write_en === 1'b1) begin
                wr_cnt++;
                if (exp_load_q.size() == 0) check_eq("load_extra", 32'(exp_load_q.size()), 32'd1);
                else                        check_eq("pc_load_val", 32'(pc_load_val), 32'(exp_load_q.pop_front()));
            end
            if (pc_inc_en === 1'b1 || pc_write_en === 1'b1)
                check_eq("inc_wr_excl", 32'({pc_inc_en, pc_write_en} != 2'b11), 32'd1);
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                if (exp_instr_q.size() == 0) check_eq("instr_extra", 32'(exp_instr_q.size()), 32'd1);
                else                         check_eq("instr", 32'(instr), 32'(exp_instr_q.pop_front()));
            end
        end
    end

    task automatic preset_pc(input logic [15:0] v);
        pc_preset_val = v;
        pc_preset_en  = 1'b1;
        tick();
        pc_preset_en  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 60 && instr_valid !== 1'b1; i++) tick();
        check_eq(tag, 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_req_addr(input string tag, input logic [15:0] a);
        for (int i = 0; i < 60 && !(mem_rd_req === 1'b1 && mem_addr === a); i++) tick();
        check_eq(tag, 32'({mem_rd_req, mem_addr}), 32'({1'b1, a}));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60 && busy !== 1'b0; i++) tick();
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int inc0;
        int wr0;
        tick(3);
        check_eq("rst_busy",  32'(busy), 32'd0);
        check_eq("rst_req",   32'(mem_rd_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_inc",   32'(pc_inc_en), 32'd0);
        check_eq("rst_wr",    32'(pc_write_en), 32'd0);
        check_eq("rst_instr", 32'(instr), 32'd0);
        rst_en = 1'b0;
        mon_en = 1'b1;

        // Basic fetch, back-to-back fetch, then back-pressure on the second word.
        lat = 2;
        preset_pc(16'h0010);
        exp_addr_q.push_back(16'h0010);
        exp_instr_q.push_back(mem_word(16'h0010));
        exp_addr_q.push_back(16'h0011);
        exp_instr_q.push_back(mem_word(16'h0011));
        pulse_start();
        check_eq("start_busy", 32'(busy), 32'd1);
        wait_valid("valid_1");
        check_eq("instr_1", 32'(instr), 32'hA55A);
        check_eq("inc_pulse_1", 32'(pc_inc_en), 32'd1);
        tick();
        instr_ready = 1'b0;
        inc0 = inc_cnt;
        wait_valid("valid_2");
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_instr", 32'(instr), 32'(mem_word(16'h0011)));
            check_eq("bp_valid", 32'(instr_valid), 32'd1);
            check_eq("bp_no_req", 32'(mem_rd_req), 32'd0);
            tick();
        end
        check_eq("bp_inc_once", 32'(inc_cnt - inc0), 32'd1);
        halt = 1'b1;
        instr_ready = 1'b1;
        tick();
        halt = 1'b0;
        check_eq("bp_idle", 32'(busy), 32'd0);
        check_eq("bp_valid_drop", 32'(instr_valid), 32'd0);
        tick(3);
        check_eq("bp_req_quiet", 32'(mem_rd_req), 32'd0);
        check_eq("bp_pc", 32'(pc_reg), 32'h0012);

        // Branch while a read is outstanding: acked word discarded, PC loaded with target.
        lat = 4;
        preset_pc(16'h0040);
        exp_addr_q.push_back(16'h0040);
        exp_load_q.push_back(16'h0200);
        exp_addr_q.push_back(16'h0200);
        exp_instr_q.push_back(mem_word(16'h0200));
        inc0 = inc_cnt;
        wr0  = wr_cnt;
        pulse_start();
        wait_req_addr("req_0040", 16'h0040);
        branch_req = 1'b1;
        branch_target = 16'h0200;
        tick();
        branch_req = 1'b0;
        wait_req_addr("req_0200", 16'h0200);
        check_eq("br_req_inc", 32'(inc_cnt - inc0), 32'd0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_idle("br_req_idle");
        check_eq("br_req_inc_total", 32'(inc_cnt - inc0), 32'd1);
        check_eq("br_req_wr", 32'(wr_cnt - wr0), 32'd1);

        // Branch in DELIVER together with the handshake.
        lat = 1;
        preset_pc(16'h0080);
        exp_addr_q.push_back(16'h0080);
        exp_instr_q.push_back(mem_word(16'h0080));
        exp_load_q.push_back(16'h0300);
        exp_addr_q.push_back(16'h0300);
        exp_instr_q.push_back(mem_word(16'h0300));
        pulse_start();
        wait_valid("valid_0080");
        branch_req = 1'b1;
        branch_target = 16'h0300;
        tick();
        branch_req = 1'b0;
        check_eq("br_del_valid", 32'(instr_valid), 32'd0);
        check_eq("br_del_wr", 32'(pc_write_en), 32'd1);
        check_eq("br_del_load", 32'(pc_load_val), 32'h0300);
        wait_req_addr("req_0300", 16'h0300);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_idle("br_del_idle");
        check_eq("br_del_pc", 32'(pc_reg), 32'h0301);

        // Halt during REQ, then start+halt in IDLE.
        lat = 3;
        preset_pc(16'h0020);
        exp_addr_q.push_back(16'h0020);
        exp_instr_q.push_back(mem_word(16'h0020));
        pulse_start();
        wait_req_addr("req_0020", 16'h0020);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_idle("halt_idle");
        check_eq("halt_pc", 32'(pc_reg), 32'h0021);
        start = 1'b1;
        halt  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("start_halt_busy", 32'(busy), 32'd0);
            check_eq("start_halt_req", 32'(mem_rd_req), 32'd0);
        end
        start = 1'b0;
        halt  = 1'b0;

        // Reset with a request outstanding, then a late ack.
        lat = 10;
        preset_pc(16'h0050);
        pulse_start();
        wait_req_addr("req_0050", 16'h0050);
        rst_en = 1'b1;
        tick();
        rst_en = 1'b0;
        check_eq("mr_req", 32'(mem_rd_req), 32'd0);
        check_eq("mr_busy", 32'(busy), 32'd0);
        check_eq("mr_addr", 32'(mem_addr), 32'd0);
        check_eq("mr_valid", 32'(instr_valid), 32'd0);
        check_eq("mr_instr", 32'(instr), 32'd0);
        check_eq("mr_load", 32'(pc_load_val), 32'd0);
        check_eq("mr_inc_wr", 32'({pc_inc_en, pc_write_en}), 32'd0);
        late_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("late_ack_valid", 32'(instr_valid), 32'd0);
            check_eq("late_ack_busy", 32'(busy), 32'd0);
        end

        check_eq("left_addr", 32'(exp_addr_q.size()), 32'd0);
        check_eq("left_instr", 32'(exp_instr_q.size()), 32'd0);
        check_eq("left_load", 32'(exp_load_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
